lsu_mem_if: RTL and testbench
=============================

Name: lsu_mem_if

Overview:
- Load/store memory interface stage; sits directly upstream of the load sign/zero-extension stage.
- Takes one load/store request from execute (address, store data, funct3) and checks its alignment.
- Drives a word-addressed data-memory bus with byte enables, then captures the returned word.
- Delivers the addressed byte/halfword/word right-aligned on rdata_o, unextended, for the extension stage to consume together with funct3.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in WAIT without mem_rvalid_i before a bus error is reported; 8-bit counter; 0 disables the timeout.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  request valid from execute.
- req_ready_o  out  1  high only in IDLE.
- we_i  in  1  1 = store, 0 = load.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-aligned.
- funct3_i  in  3  0 B, 1 H, 2 W, 4 BU, 5 HU; 3/6/7 illegal.
- rsp_valid_o  out  1  one-cycle response pulse.
- rdata_o  out  32  load data shifted right by addr[1:0]*8 (upper bytes unmasked); 0 for stores and errors.
- funct3_o  out  3  registered funct3, valid with rsp_valid_o; feeds the extension stage.
- misalign_o  out  1  valid with rsp_valid_o; misaligned access or illegal funct3.
- bus_err_o  out  1  valid with rsp_valid_o; timeout.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  32  {addr[31:2],2'b00}.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_be_o  out  4  byte enables.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  response/completion (loads and stores).
- mem_rdata_i  in  32  read word.

Behaviour:
- Reset values:
  - FSM = IDLE, req_ready_o = 1.
  - All other outputs 0: rsp_valid_o, misalign_o, bus_err_o, mem_req_o, mem_we_o, mem_be_o, rdata_o, funct3_o, mem_addr_o, mem_wdata_o.
  - Timeout counter = 0.
- IDLE:
  - Accept on req_valid_i & req_ready_o; register we, addr, funct3 and computed be/wdata.
  - Misaligned if: funct3[1:0]==1 & addr[0]; or funct3==2 & addr[1:0]!=0; or funct3 in {3,6,7} (stores: only 0/1/2 legal).
  - Misaligned -> RESP with misalign_o=1; no bus access.
  - Otherwise -> REQ.
- Byte enables:
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
- Store data: B replicates wdata[7:0] x4; H replicates wdata[15:0] x2; W passes through.
- REQ:
  - mem_req_o=1; mem_addr_o/mem_we_o/mem_be_o/mem_wdata_o held stable until mem_gnt_i.
  - gnt & !rvalid -> WAIT.
  - gnt & rvalid in the same cycle -> RESP, capturing data.
  - mem_req_o deasserts the cycle after gnt.
- WAIT:
  - mem_req_o=0; counter increments each cycle.
  - mem_rvalid_i -> capture and go to RESP.
  - Counter reaches TIMEOUT_CYCLES (nonzero) -> RESP with bus_err_o=1, rdata_o=0.
- RESP:
  - rsp_valid_o=1 for exactly one cycle with rdata_o/funct3_o/misalign_o/bus_err_o; -> IDLE.
  - Response cannot be stalled.
  - misalign_o and bus_err_o are mutually exclusive.
- Load capture: rdata_o = mem_rdata_i >> (addr[1:0]*8), zero-filled from the top; stores give rdata_o = 0.
- Latency:
  - Request accepted at edge N; mem_req_o high in cycle N+1.
  - With gnt & rvalid in N+1, rsp_valid_o is high in N+2 (minimum).
  - Misaligned request: rsp_valid_o in N+1.
- mem_rvalid_i outside WAIT/REQ-with-gnt is ignored. One outstanding transaction max.
- req_valid_i while not IDLE is ignored (ready low); the requester holds it.
- rst_i mid-transaction returns to IDLE next edge with all outputs at reset values; a late mem_rvalid_i is discarded.

Test Plan:
- LB addr=0x103, mem_rdata=0xAABBCCDD, gnt+rvalid in first REQ cycle -> mem_addr_o=0x100, mem_be_o=4'b1000, rsp_valid_o one cycle later with rdata_o=0x000000AA, funct3_o=0.
- SH addr=0x22, wdata=0x1234BEEF -> mem_we_o=1, mem_be_o=4'b1100, mem_wdata_o=0xBEEFBEEF; after rvalid, rsp_valid_o=1, rdata_o=0.
- LW addr=0x41 -> no mem_req_o; rsp_valid_o next cycle with misalign_o=1; funct3=6 at an aligned address -> same.
- LHU addr=0x8, gnt delayed 3 cycles, rvalid 2 cycles later, mem_rdata=0x0000F00D -> request signals stable throughout, rdata_o=0x0000F00D, req_ready_o low until after RESP.
- TIMEOUT_CYCLES=4, gnt given, no rvalid -> rsp_valid_o with bus_err_o=1, rdata_o=0; then a new request is accepted normally.
- rst_i asserted in WAIT, rvalid arrives the cycle after -> outputs at reset values, no rsp_valid_o, req_ready_o=1.

Source files
------------

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store memory interface; checks alignment, drives a word bus with byte enables and right-aligns load data.
module lsu_mem_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    output logic        rsp_valid_o,
    output logic [31:0] rdata_o,
    output logic [2:0]  funct3_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic        we_q, misalign_q, bus_err_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  funct3_q;
    logic [3:0]  be_q;
    logic [7:0]  cnt;
    logic        accept, mis_c, timeout;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, load_data;
    logic [7:0]  cnt_nxt;
    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == RESP);
    assign mem_req_o   = (state == REQ);
    assign mem_we_o    = mem_req_o & we_q;
    assign mem_be_o    = mem_req_o ? be_q : 4'b0000;
    assign mem_addr_o  = {addr_q[31:2], 2'b00};
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign funct3_o    = funct3_q;
    assign misalign_o  = misalign_q;
    assign bus_err_o   = bus_err_q;
    assign accept      = req_valid_i & req_ready_o;
    always_comb begin
        be_c = (funct3_i[1:0] == 2'd0) ? 4'b0001 << addr_i[1:0] :
               (funct3_i[1:0] == 2'd1) ? 4'b0011 << {addr_i[1], 1'b0} : 4'b1111;
        wdata_c = (funct3_i[1:0] == 2'd0) ? {4{wdata_i[7:0]}} :
                  (funct3_i[1:0] == 2'd1) ? {2{wdata_i[15:0]}} : wdata_i;
        // stores only have B/H/W encodings; unsigned variants are illegal for them
        mis_c = (funct3_i[1:0] == 2'd3) || (funct3_i == 3'd6) || (we_i && funct3_i[2]) ||
                (funct3_i[1:0] == 2'd1 && addr_i[0]) ||
                (funct3_i == 3'd2 && addr_i[1:0] != 2'b00);
        cnt_nxt   = cnt + 8'd1;
        timeout   = (TIMEOUT_CYCLES != 0) && (cnt_nxt == 8'(TIMEOUT_CYCLES));
        load_data = we_q ? 32'd0 : mem_rdata_i >> {addr_q[1:0], 3'b000};
        state_nxt = state;
        case (state)
            IDLE: state_nxt = accept ? (mis_c ? RESP : REQ) : IDLE;
            REQ:  state_nxt = mem_gnt_i ? (mem_rvalid_i ? RESP : WAIT) : REQ;
            WAIT: state_nxt = (mem_rvalid_i || timeout) ? RESP : WAIT;
            RESP: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            funct3_q   <= '0;
            be_q       <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            cnt        <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q       <= we_i;
                addr_q     <= addr_i;
                wdata_q    <= wdata_c;
                funct3_q   <= funct3_i;
                be_q       <= be_c;
                misalign_q <= mis_c;
                bus_err_q  <= 1'b0;
                rdata_q    <= '0;
                cnt        <= '0;
            end
            if (state == REQ && mem_gnt_i && mem_rvalid_i)
                rdata_q <= load_data;
            if (state == WAIT) begin
                cnt <= cnt_nxt;
                if (mem_rvalid_i)
                    rdata_q <= load_data;
                else if (timeout)
                    bus_err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed checks of lsu_mem_if with hand-computed expectations.
module tb_lsu_mem_if;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [2:0]  funct3_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rdata_o;
    logic [2:0]  funct3_o;
    logic        misalign_o;
    logic        bus_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    int compared = 0;
    int mismatched = 0;
    int n;
    lsu_mem_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .funct3_i(funct3_i),
        .rsp_valid_o(rsp_valid_o), .rdata_o(rdata_o), .funct3_o(funct3_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
        req_valid_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd; funct3_i = f3;
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask
    initial begin
        repeat (2) @(negedge clk_i);
        chk("rst_ready", req_ready_o, 1);
        chk("rst_rsp", rsp_valid_o, 0);
        chk("rst_memreq", mem_req_o, 0);
        chk("rst_be", mem_be_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        // LB 0x103, gnt+rvalid in the first REQ cycle
        issue(1'b0, 32'h103, 32'h0, 3'd0);
        chk("lb_req", mem_req_o, 1);
        chk("lb_addr", mem_addr_o, 32'h100);
        chk("lb_be", mem_be_o, 4'b1000);
        chk("lb_we", mem_we_o, 0);
        chk("lb_ready", req_ready_o, 0);
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAABBCCDD;
        @(negedge clk_i);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        chk("lb_rsp", rsp_valid_o, 1);
        chk("lb_rdata", rdata_o, 32'h000000AA);
        chk("lb_f3", funct3_o, 0);
        chk("lb_mis", misalign_o, 0);
        chk("lb_err", bus_err_o, 0);
        chk("lb_req_off", mem_req_o, 0);
        @(negedge clk_i);
        chk("lb_rsp_pulse", rsp_valid_o, 0);
        chk("lb_ready_back", req_ready_o, 1);
        // SH 0x22
        issue(1'b1, 32'h22, 32'h1234BEEF, 3'd1);
        chk("sh_we", mem_we_o, 1);
        chk("sh_be", mem_be_o, 4'b1100);
        chk("sh_wdata", mem_wdata_o, 32'hBEEFBEEF);
        chk("sh_addr", mem_addr_o, 32'h20);
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        chk("sh_wait_req", mem_req_o, 0);
        chk("sh_wait_rsp", rsp_valid_o, 0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55667788;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        chk("sh_rsp", rsp_valid_o, 1);
        chk("sh_rdata", rdata_o, 0);
        @(negedge clk_i);
        // SB lane replication
        issue(1'b1, 32'h41, 32'h000000A5, 3'd0);
        chk("sb_wdata", mem_wdata_o, 32'hA5A5A5A5);
        chk("sb_be", mem_be_o, 4'b0010);
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        chk("sb_rsp", rsp_valid_o, 1);
        @(negedge clk_i);
        // misaligned LW and illegal funct3
        issue(1'b0, 32'h41, 32'h0, 3'd2);
        chk("lw_mis_rsp", rsp_valid_o, 1);
        chk("lw_mis_flag", misalign_o, 1);
        chk("lw_mis_noreq", mem_req_o, 0);
        chk("lw_mis_err", bus_err_o, 0);
        chk("lw_mis_rdata", rdata_o, 0);
        @(negedge clk_i);
        issue(1'b0, 32'h40, 32'h0, 3'd6);
        chk("f6_rsp", rsp_valid_o, 1);
        chk("f6_mis", misalign_o, 1);
        chk("f6_f3", funct3_o, 6);
        chk("f6_noreq", mem_req_o, 0);
        @(negedge clk_i);
        // SHU is not a legal store
        issue(1'b1, 32'h40, 32'h0, 3'd5);
        chk("shu_mis", misalign_o, 1);
        @(negedge clk_i);
        // LHU 0x8 with delayed gnt and rvalid
        issue(1'b0, 32'h8, 32'h0, 3'd5);
        for (int i = 0; i < 3; i++) begin
            chk("lhu_hold_req", mem_req_o, 1);
            chk("lhu_hold_addr", mem_addr_o, 32'h8);
            chk("lhu_hold_be", mem_be_o, 4'b0011);
            chk("lhu_hold_ready", req_ready_o, 0);
            if (i == 2) mem_gnt_i = 1'b1;
            @(negedge clk_i);
        end
        mem_gnt_i = 1'b0;
        chk("lhu_wait_req", mem_req_o, 0);
        chk("lhu_wait_ready", req_ready_o, 0);
        @(negedge clk_i);
        chk("lhu_wait2_rsp", rsp_valid_o, 0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000F00D;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        chk("lhu_rsp", rsp_valid_o, 1);
        chk("lhu_rdata", rdata_o, 32'h0000F00D);
        chk("lhu_f3", funct3_o, 5);
        chk("lhu_ready_resp", req_ready_o, 0);
        @(negedge clk_i);
        chk("lhu_ready_after", req_ready_o, 1);
        // LH 0xA shifts the upper halfword down
        issue(1'b0, 32'hA, 32'h0, 3'd1);
        chk("lh_be", mem_be_o, 4'b1100);
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hF00D1234;
        @(negedge clk_i);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        chk("lh_rdata", rdata_o, 32'h0000F00D);
        @(negedge clk_i);
        // timeout after 4 WAIT cycles
        issue(1'b0, 32'h10, 32'h0, 3'd2);
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        n = 0;
        while (!rsp_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("to_cycles", n, 4);
        chk("to_rsp", rsp_valid_o, 1);
        chk("to_err", bus_err_o, 1);
        chk("to_rdata", rdata_o, 0);
        chk("to_mis", misalign_o, 0);
        @(negedge clk_i);
        chk("to_ready", req_ready_o, 1);
        issue(1'b0, 32'h1, 32'h0, 3'd4);
        chk("lbu_req", mem_req_o, 1);
        chk("lbu_be", mem_be_o, 4'b0010);
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11223344;
        @(negedge clk_i);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        chk("lbu_rsp", rsp_valid_o, 1);
        chk("lbu_rdata", rdata_o, 32'h00112233);
        chk("lbu_err", bus_err_o, 0);
        @(negedge clk_i);
        // reset in WAIT, late rvalid discarded
        issue(1'b0, 32'h30, 32'h0, 3'd2);
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        chk("mrst_ready", req_ready_o, 1);
        chk("mrst_rsp", rsp_valid_o, 0);
        chk("mrst_req", mem_req_o, 0);
        chk("mrst_addr", mem_addr_o, 0);
        chk("mrst_f3", funct3_o, 0);
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        chk("mrst_late_rsp", rsp_valid_o, 0);
        chk("mrst_late_rdata", rdata_o, 0);
        chk("mrst_late_ready", req_ready_o, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
